// File: rtl/csi2_pkg.sv
// csi2_pkg -- shared constants, header field offsets and ECC status type for the
// CSI-2 packet-header ECC checker.
`default_nettype none

package csi2_pkg;

   localparam int DATA_W = 24;
   localparam int ECC_W  = 6;

   // Header field offsets (LSB of each byte)
   localparam int HDR_DI_LSB     = 0;
   localparam int HDR_WC_LSB_LSB = 8;
   localparam int HDR_WC_MSB_LSB = 16;
   localparam int HDR_ECC_LSB    = 24;

   // Hamming parity column of each data bit; none has a single bit set, so
   // one-hot syndromes unambiguously point at the ECC byte itself.
   localparam logic [ECC_W-1:0] ECC_COLS [DATA_W] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
   };

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_CORRECTED = 2'd1,
      ST_ERR       = 2'd2
   } ecc_status_e;

   function automatic logic [ECC_W-1:0] calc_ecc(input logic [DATA_W-1:0] data);
      logic [ECC_W-1:0] ecc;
      ecc = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (data[i]) ecc = ecc ^ ECC_COLS[i];
      end
      return ecc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/csi2_header_ecc_check_if.sv
// csi2_header_ecc_check_if -- header input, corrected-header output and
// statistics bundle between the lane aligner, the checker and the parser.
`default_nettype none

interface csi2_header_ecc_check_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 I_hdr_valid;
   logic [31:0]          I_hdr;
   logic                 I_cnt_clr;
   logic                 O_hdr_valid;
   logic [31:0]          O_hdr;
   logic                 O_ecc_ok;
   logic                 O_ecc_corrected;
   logic                 O_ecc_err;
   logic [CNT_WIDTH-1:0] O_corr_cnt;
   logic [CNT_WIDTH-1:0] O_err_cnt;

   modport master (
      output I_hdr_valid, I_hdr, I_cnt_clr,
      input  O_hdr_valid, O_hdr, O_ecc_ok, O_ecc_corrected, O_ecc_err,
             O_corr_cnt, O_err_cnt
   );

   modport slave (
      input  I_hdr_valid, I_hdr, I_cnt_clr,
      output O_hdr_valid, O_hdr, O_ecc_ok, O_ecc_corrected, O_ecc_err,
             O_corr_cnt, O_err_cnt
   );
endinterface

`default_nettype wire

// File: rtl/csi2_ecc_syndrome.sv
// csi2_ecc_syndrome -- combinational CSI-2 header ECC: calculated ECC over the
// 24 data bits and syndrome against the received 6-bit ECC.
`default_nettype none

module csi2_ecc_syndrome
   import csi2_pkg::*;
(
   input  wire logic [DATA_W-1:0] i_data,
   input  wire logic [ECC_W-1:0]  i_ecc_rx,
   output logic      [ECC_W-1:0]  o_ecc_calc,
   output logic      [ECC_W-1:0]  o_syndrome
);

   always_comb begin
      o_ecc_calc = calc_ecc(i_data);
      o_syndrome = o_ecc_calc ^ i_ecc_rx;
   end

endmodule

`default_nettype wire

// File: rtl/csi2_header_ecc_check.sv
// csi2_header_ecc_check -- two-stage CSI-2 header ECC check/correct with
// optional saturating statistics counters (enabled by CSI2_ECC_STATS_EN).
`default_nettype none

module csi2_header_ecc_check
   import csi2_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  wire logic                I_clk,
   input  wire logic                I_rst,
   csi2_header_ecc_check_if.slave   hdr_if
);

   logic [ECC_W-1:0]  ecc_calc_w;
   logic [ECC_W-1:0]  syndrome_w;

   logic              v1_d, v1_q;
   logic [DATA_W-1:0] data1_d, data1_q;
   logic [ECC_W-1:0]  syn1_d, syn1_q;

   logic              hdr_valid_d, hdr_valid_q;
   logic [31:0]       hdr_d, hdr_q;
   logic              ok_d, ok_q;
   logic              corr_d, corr_q;
   logic              err_d, err_q;

   logic [DATA_W-1:0] flip_mask;
   logic [DATA_W-1:0] corr_data;
   logic              syn_one_hot;
   ecc_status_e       status;

   csi2_ecc_syndrome u_syndrome (
      .i_data     (hdr_if.I_hdr[HDR_DI_LSB +: DATA_W]),
      .i_ecc_rx   (hdr_if.I_hdr[HDR_ECC_LSB +: ECC_W]),
      .o_ecc_calc (ecc_calc_w),
      .o_syndrome (syndrome_w)
   );

   // Stage 1: capture data and syndrome
   always_comb begin
      v1_d    = hdr_if.I_hdr_valid;
      data1_d = data1_q;
      syn1_d  = syn1_q;
      if (hdr_if.I_hdr_valid) begin
         data1_d = hdr_if.I_hdr[HDR_DI_LSB +: DATA_W];
         syn1_d  = syndrome_w;
      end
   end

   // Stage 2: classify and correct; flip_mask stays zero unless S matches a column
   always_comb begin
      flip_mask = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (syn1_q == ECC_COLS[i]) flip_mask[i] = 1'b1;
      end
      syn_one_hot = (syn1_q != '0) && ((syn1_q & (syn1_q - 6'd1)) == '0);

      if (syn1_q == '0)                status = ST_OK;
      else if ((|flip_mask) || syn_one_hot) status = ST_CORRECTED;
      else                             status = ST_ERR;

      corr_data   = data1_q ^ flip_mask;
      hdr_valid_d = v1_q;
      hdr_d       = hdr_q;
      ok_d        = ok_q;
      corr_d      = corr_q;
      err_d       = err_q;
      if (v1_q) begin
         hdr_d  = {2'b00, calc_ecc(corr_data), corr_data};
         ok_d   = (status == ST_OK);
         corr_d = (status == ST_CORRECTED);
         err_d  = (status == ST_ERR);
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         v1_q        <= 1'b0;
         data1_q     <= '0;
         syn1_q      <= '0;
         hdr_valid_q <= 1'b0;
         hdr_q       <= '0;
         ok_q        <= 1'b0;
         corr_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         data1_q     <= data1_d;
         syn1_q      <= syn1_d;
         hdr_valid_q <= hdr_valid_d;
         hdr_q       <= hdr_d;
         ok_q        <= ok_d;
         corr_q      <= corr_d;
         err_q       <= err_d;
      end
   end

   assign hdr_if.O_hdr_valid     = hdr_valid_q;
   assign hdr_if.O_hdr           = hdr_q;
   assign hdr_if.O_ecc_ok        = ok_q;
   assign hdr_if.O_ecc_corrected = corr_q;
   assign hdr_if.O_ecc_err       = err_q;

`ifdef CSI2_ECC_STATS_EN
   logic [CNT_WIDTH-1:0] corr_cnt_d, corr_cnt_q;
   logic [CNT_WIDTH-1:0] err_cnt_d, err_cnt_q;

   // Clear has priority over a same-cycle increment
   always_comb begin
      corr_cnt_d = corr_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (hdr_if.I_cnt_clr) begin
         corr_cnt_d = '0;
         err_cnt_d  = '0;
      end else begin
         if (hdr_valid_q && corr_q && !(&corr_cnt_q)) corr_cnt_d = corr_cnt_q + 1'b1;
         if (hdr_valid_q && err_q  && !(&err_cnt_q))  err_cnt_d  = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         corr_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         corr_cnt_q <= corr_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign hdr_if.O_corr_cnt = corr_cnt_q;
   assign hdr_if.O_err_cnt  = err_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr    = hdr_if.I_cnt_clr;
   assign hdr_if.O_corr_cnt = '0;
   assign hdr_if.O_err_cnt  = '0;
`endif

endmodule

`default_nettype wire
